// File: rtl/mul_defs.sv
// mul_defs: shared multiplier op codes, FSM state encodings and default width.
package mul_defs;
    localparam int N_DEF = 32;
    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_NEG  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
endpackage

// File: rtl/mul32.sv
// mul32: combinational unsigned N x N array multiplier.
module mul32 #(
    parameter int N = mul_defs::N_DEF
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);
    assign {hi, lo} = a * b;
endmodule

// File: rtl/mul_ctrl.sv
// mul_ctrl: sign-magnitude multicycle multiplier controller (MUL/MULH/MULHSU/MULHU).
module mul_ctrl
    import mul_defs::*;
#(
    parameter int N       = N_DEF,
    parameter int MUL_LAT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   op,
    input  logic [N-1:0] rs1,
    input  logic [N-1:0] rs2,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         busy
);
    logic [1:0]     state, op_q;
    logic [3:0]     cnt;
    logic [N-1:0]   mag_a, mag_b, res, hi, lo;
    logic [2*N-1:0] prod, prod_s;
    logic           neg, s1, s2;

    assign in_ready  = state == S_IDLE;
    assign out_valid = state == S_DONE;
    assign busy      = state != S_IDLE;
    assign result    = res;
    assign s1        = (op == OP_MULH || op == OP_MULHSU) && rs1[N-1];
    assign s2        = (op == OP_MULH) && rs2[N-1];
    assign prod_s    = neg ? -prod : prod;

    // Array is fed only from the magnitude registers; its output is sampled at the end of CALC.
    mul32 #(.N(N)) u_mul (.a(mag_a), .b(mag_b), .hi(hi), .lo(lo));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            mag_a <= '0;
            mag_b <= '0;
            neg   <= 1'b0;
            op_q  <= '0;
            prod  <= '0;
            res   <= '0;
        end else if (flush) begin
            state <= S_IDLE;
            cnt   <= '0;
            neg   <= 1'b0;
            res   <= '0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    state <= S_CALC;
                    cnt   <= 4'(MUL_LAT - 1);
                    mag_a <= s1 ? -rs1 : rs1;
                    mag_b <= s2 ? -rs2 : rs2;
                    neg   <= s1 ^ s2;
                    op_q  <= op;
                end
                S_CALC: if (cnt == '0) begin
                    prod  <= {hi, lo};
                    state <= S_NEG;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                S_NEG: begin
                    res   <= op_q == OP_MUL ? prod_s[N-1:0] : prod_s[2*N-1:N];
                    state <= S_DONE;
                end
                default: if (out_ready) begin
                    state <= S_IDLE;
                    res   <= '0;
                end
            endcase
        end
    end
endmodule
